// File: rtl/mux_pkg.sv
// Shared constants and helpers for the registered N-channel mux family.
package mux_pkg;

  localparam logic MODE_RR    = 1'b0;
  localparam logic MODE_FORCE = 1'b1;

  // Select/index width for an N-channel mux; never narrower than one bit.
  function automatic int calc_selw(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: searches from last_grant+1 upward, modulo N.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int N    = 4,
  parameter int SELW = calc_selw(N)
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] last_grant,
  output logic [N-1:0]    gnt,
  output logic [SELW-1:0] gnt_idx,
  output logic            gnt_valid
);

  int cand;

  always_comb begin
    gnt       = '0;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    cand      = 0;
    // Offset 1 first so the previous winner has lowest priority.
    for (int k = 1; k <= N; k++) begin
      cand = (int'(last_grant) + k) % N;
      if (!gnt_valid && req[cand]) begin
        gnt_valid = 1'b1;
        gnt_idx   = SELW'(cand);
        gnt[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_mux_reg.sv
// N-channel valid/ready multiplexer with registered output and
// round-robin or forced channel selection.
module rr_mux_reg
  import mux_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int SELW  = calc_selw(N)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N-1:0]       in_valid,
  input  logic [N*WIDTH-1:0] in_data,
  output logic [N-1:0]       in_ready,
  input  logic               mode,
  input  logic [SELW-1:0]    force_sel,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [SELW-1:0]    out_src,
  input  logic               out_ready
);

  localparam int NPAD = 1 << SELW;

  logic               out_valid_reg;
  logic [WIDTH-1:0]   out_data_reg;
  logic [SELW-1:0]    out_src_reg;
  logic [SELW-1:0]    last_grant_reg;

  logic [WIDTH-1:0]   ch_data [NPAD];
  logic [NPAD-1:0]    valid_pad;
  logic [N-1:0]       rr_gnt;
  logic [SELW-1:0]    rr_idx;
  logic               rr_valid;
  logic               force_valid;
  logic               grant_valid;
  logic [SELW-1:0]    grant_idx;
  logic               load_en;

  // Pad the channel view to a power of two so an out-of-range force_sel
  // simply sees an idle channel.
  generate
    for (genvar gi = 0; gi < NPAD; gi++) begin : g_ch
      if (gi < N) begin : g_real
        assign ch_data[gi] = in_data[gi*WIDTH +: WIDTH];
      end else begin : g_pad
        assign ch_data[gi] = '0;
      end
    end
  endgenerate

  assign valid_pad = NPAD'(in_valid);

  rr_arbiter #(
    .N    (N),
    .SELW (SELW)
  ) u_arb (
    .req        (in_valid),
    .last_grant (last_grant_reg),
    .gnt        (rr_gnt),
    .gnt_idx    (rr_idx),
    .gnt_valid  (rr_valid)
  );

  assign force_valid = valid_pad[force_sel];
  assign grant_valid = (mode == MODE_FORCE) ? force_valid : rr_valid;
  assign grant_idx   = (mode == MODE_FORCE) ? force_sel   : rr_idx;
  assign load_en     = !out_valid_reg || out_ready;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_ready
      assign in_ready[gi] = !reset && grant_valid && load_en &&
                            (grant_idx == SELW'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_reg  <= 1'b0;
      out_data_reg   <= '0;
      out_src_reg    <= '0;
      last_grant_reg <= SELW'(N - 1);
    end else if (load_en) begin
      if (grant_valid) begin
        out_valid_reg <= 1'b1;
        out_data_reg  <= ch_data[grant_idx];
        out_src_reg   <= grant_idx;
        if (mode == MODE_RR) begin
          last_grant_reg <= grant_idx;
        end
      end else begin
        // Drain: data and source are kept for observability.
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_src   = out_src_reg;

  logic unused_ok;
  assign unused_ok = ^rr_gnt;

endmodule

// File: tb/tb_rr_mux_reg.sv
// Directed self-checking bench for rr_mux_reg (N=4, WIDTH=32).
module tb_rr_mux_reg;

  localparam int WIDTH = 32;
  localparam int N     = 4;
  localparam int SELW  = 2;

  logic               clk = 1'b0;
  logic               reset;
  logic [N-1:0]       in_valid;
  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_ready;
  logic               mode;
  logic [SELW-1:0]    force_sel;
  logic               out_valid;
  logic [WIDTH-1:0]   out_data;
  logic [SELW-1:0]    out_src;
  logic               out_ready;

  int errors = 0;
  int checks = 0;

  rr_mux_reg #(.WIDTH(WIDTH), .N(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .mode      (mode),
    .force_sel (force_sel),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic check_out(input string tag, input logic v, input logic [31:0] d, input logic [1:0] s);
    check({tag, ".valid"}, 32'(out_valid), 32'(v));
    check({tag, ".data"},  out_data, d);
    check({tag, ".src"},   32'(out_src), 32'(s));
  endtask

  task automatic set_ch(input int ch, input logic [31:0] d);
    in_data[ch*WIDTH +: WIDTH] = d;
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 4'hF;
    out_ready = 1'b1;
    mode      = 1'b0;
    force_sel = '0;
    for (int i = 0; i < N; i++) set_ch(i, 32'hA0 + 32'(i));

    // Reset held for two cycles with every channel requesting.
    @(negedge clk);
    check("rst1.ready", 32'(in_ready), 32'h0);
    check_out("rst1", 1'b0, 32'h0, 2'd0);
    @(negedge clk);
    check("rst2.ready", 32'(in_ready), 32'h0);
    check_out("rst2", 1'b0, 32'h0, 2'd0);

    // Release: round-robin 0,1,2,3,0 at one word per cycle.
    reset = 1'b0;
    #1 check("rr.first_ready", 32'(in_ready), 32'h1);
    @(negedge clk); check_out("rr0", 1'b1, 32'hA0, 2'd0);
    check("rr0.ready", 32'(in_ready), 32'h2);
    @(negedge clk); check_out("rr1", 1'b1, 32'hA1, 2'd1);
    check("rr1.ready", 32'(in_ready), 32'h4);
    @(negedge clk); check_out("rr2", 1'b1, 32'hA2, 2'd2);
    check("rr2.ready", 32'(in_ready), 32'h8);
    @(negedge clk); check_out("rr3", 1'b1, 32'hA3, 2'd3);
    check("rr3.ready", 32'(in_ready), 32'h1);
    @(negedge clk); check_out("rr4", 1'b1, 32'hA0, 2'd0);

    // Bring pointer to 2, then only channels 1 and 3 request: 3,1,3.
    in_valid = 4'b0100;
    @(negedge clk); check_out("ws.ptr2", 1'b1, 32'hA2, 2'd2);
    in_valid = 4'b1010;
    #1 check("ws.ready3", 32'(in_ready), 32'h8);
    @(negedge clk); check_out("ws.g3a", 1'b1, 32'hA3, 2'd3);
    check("ws.ready1", 32'(in_ready), 32'h2);
    @(negedge clk); check_out("ws.g1", 1'b1, 32'hA1, 2'd1);
    @(negedge clk); check_out("ws.g3b", 1'b1, 32'hA3, 2'd3);

    // Backpressure: three stalled cycles, then accept ch0 immediately.
    in_valid  = 4'b0001;
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1 check($sformatf("bp%0d.ready", c), 32'(in_ready), 32'h0);
      @(negedge clk); check_out($sformatf("bp%0d", c), 1'b1, 32'hA3, 2'd3);
    end
    out_ready = 1'b1;
    #1 check("bp.release_ready", 32'(in_ready), 32'h1);
    @(negedge clk); check_out("bp.new", 1'b1, 32'hA0, 2'd0);

    // Forced select of channel 2 with all channels requesting.
    mode      = 1'b1;
    force_sel = 2'd2;
    in_valid  = 4'hF;
    set_ch(2, 32'hC2);
    #1 check("fs.ready", 32'(in_ready), 32'h4);
    @(negedge clk); check_out("fs.g2", 1'b1, 32'hC2, 2'd2);
    in_valid = 4'b1011;
    #1 check("fs.nogrant_ready", 32'(in_ready), 32'h0);
    @(negedge clk); check_out("fs.drain", 1'b0, 32'hC2, 2'd2);
    // Back to RR: pointer still 0 from before forced mode, so ch1 wins.
    mode     = 1'b0;
    in_valid = 4'hF;
    set_ch(2, 32'hA2);
    #1 check("fs.rr_ready", 32'(in_ready), 32'h2);
    @(negedge clk); check_out("fs.rr", 1'b1, 32'hA1, 2'd1);

    // Mid-operation reset drops a held word and restores the pointer.
    set_ch(2, 32'hDEAD);
    in_valid = 4'b0100;
    @(negedge clk); check_out("mr.held", 1'b1, 32'hDEAD, 2'd2);
    out_ready = 1'b0;
    in_valid  = 4'hF;
    reset     = 1'b1;
    #1 check("mr.rst_ready", 32'(in_ready), 32'h0);
    @(negedge clk); check_out("mr.rst", 1'b0, 32'h0, 2'd0);
    reset     = 1'b0;
    out_ready = 1'b1;
    #1 check("mr.first_ready", 32'(in_ready), 32'h1);
    @(negedge clk); check_out("mr.first", 1'b1, 32'hA0, 2'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rr_mux_reg.md
Name: rr_mux_reg

Overview:
- Parametrised N-channel multiplexer with a registered output and a valid/ready handshake on every channel.
- Generalises the fixed mux2/mux4/mux8 family in three ways: any width, any channel count, and a choice of round-robin arbitration or forced select.
- First users: the shared memory-port path (instruction fetch vs. data access) and multi-source write-back collection in the pipelined core.

Parameters:
- WIDTH, 32, data bits per channel.
- N, 4, number of input channels; N >= 2.
- SELW, $clog2(N), width of the select and source-index fields; derived, never overridden.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  N  bit i: channel i presents data.
- in_data  input  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_ready  output  N  bit i: channel i accepted this cycle.
- mode  input  1  0 = round-robin arbitration (MODE_RR), 1 = forced select (MODE_FORCE).
- force_sel  input  SELW  channel index used when mode = 1.
- out_valid  output  1  output register holds valid data.
- out_data  output  WIDTH  registered selected data.
- out_src  output  SELW  index of the channel that supplied out_data.
- out_ready  input  1  consumer accepts out_data this cycle.

Behaviour:
- Reset (synchronous, active-high, dominates all other inputs):
  - out_valid = 0, out_data = 0, out_src = 0.
  - Round-robin pointer last_grant = N-1, so channel 0 has top priority on the first arbitration.
  - in_ready = 0 during the reset cycle.
  - Reset asserted mid-operation drops any held output word with no handshake.
- Load condition: load_en = !out_valid || out_ready. The output register may refill in the same cycle it drains, giving throughput of 1 word/cycle.
- Grant in MODE_RR:
  - Search channels last_grant+1, last_grant+2, ... modulo N; grant the first with in_valid = 1.
  - Wrap-around: when last_grant = N-1, the search starts at 0.
- Grant in MODE_FORCE:
  - Grant force_sel if in_valid[force_sel] = 1; otherwise no grant.
  - force_sel >= N (possible only when N is not a power of two) means no grant and no error.
- Handshake:
  - in_ready[g] = grant_valid && load_en, combinational. At most one in_ready bit is high in any cycle.
  - in_ready depends combinationally on in_valid, mode, force_sel and out_ready; there is no dependency from in_ready back to in_valid.
- Transfer on a clock edge with in_ready[g] = 1:
  - out_data <= in_data[g], out_src <= g, out_valid <= 1.
  - In MODE_RR only, last_grant <= g. MODE_FORCE never moves the pointer.
- Drain with no grant: out_valid && out_ready && no grant gives out_valid <= 0. out_data and out_src hold their old values.
- Stall: out_valid && !out_ready leaves the output register, out_src and last_grant unchanged, and all in_ready = 0.
- Latency: 1 cycle from accepted input to out_valid.
- Producer contract: in_valid and in_data stay stable until accepted. The block does not check this.
- Mode or force_sel changes take effect on the next grant decision and never disturb a word already in the output register.
- No combinational path from any input to out_valid, out_data or out_src.

Decomposition:
- Shared package (mux_pkg), containing:
  - localparams MODE_RR = 1'b0 and MODE_FORCE = 1'b1.
  - A function computing SELW from N, for consistent use by instantiators.
- One sub-module, rr_arbiter:
  - Parameter N; inputs req[N], last_grant[SELW]; outputs gnt[N] (one-hot), gnt_idx[SELW], gnt_valid.
  - Purely combinational. The pointer register lives in rr_mux_reg.
- Forced-select qualification and the output register stay in the top module.

Test Plan:
- Reset: hold reset 2 cycles with all in_valid = 1 -> out_valid = 0, out_data = 0, out_src = 0, in_ready = 0; first grant after release goes to channel 0.
- RR fairness: N = 4, all in_valid = 1, out_ready = 1, data = 0xA0+i -> out_src sequence 0,1,2,3,0 and out_data sequence 0xA0, 0xA1, 0xA2, 0xA3, 0xA0 on consecutive cycles (1 word/cycle).
- Wrap and skip: last_grant = 2, only channels 1 and 3 valid -> grants 3, then 1, then 3.
- Backpressure: out_valid = 1 and out_ready = 0 for 3 cycles with ch0 valid -> output word, out_src and in_ready = 0 all stable; out_ready = 1 -> ch0 accepted the same cycle and the new word is visible next cycle.
- Forced mode: mode = 1, force_sel = 2, channels 0..3 valid -> only in_ready[2] = 1; in_valid[2] = 0 -> no grant and out_valid falls after drain; switch back to mode = 0 -> pointer unchanged from before forced mode.
- Mid-operation reset: out_valid = 1 with 0xDEAD held, reset pulsed for 1 cycle -> out_valid = 0 next cycle, pointer back to N-1, first post-reset grant is channel 0.
